// File: rtl/rr_req_encoder4_2.sv
`default_nettype none
// ============================================================================
// Module   : rr_req_encoder4_2
// Summary  : 4-input round-robin request encoder driving a registered grant ID
//            and enable, with a one-cycle dead time between grants.
// Revision : 1.0 - initial release
// ============================================================================

module rr_req_encoder4_2 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HOLD_W   = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] REQ,
   input  logic       DONE,
   output logic [1:0] Data,
   output logic       EN,
   output logic       BUSY,
   output logic       TMO
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] c_CNT_SAT   = {HOLD_W{1'b1}};
   localparam logic [HOLD_W-1:0] c_CNT_ONE   = {{(HOLD_W-1){1'b0}}, 1'b1};

   state_t            state_q;
   logic [1:0]        data_q;
   logic [1:0]        last_q;
   logic              en_q;
   logic              busy_q;
   logic              tmo_q;
   logic [HOLD_W-1:0] cnt_q;
   logic [HOLD_W-1:0] cnt_d;

   logic              w_win_found;
   logic [1:0]        w_win_id;
   logic [1:0]        w_idx;
   logic              w_owner_req;
   logic              w_tmo_hit;
   logic              w_release;

   // Scan from farthest to nearest so the first set bit after LAST wins.
   always_comb begin
      w_win_found = 1'b0;
      w_win_id    = last_q;
      w_idx       = last_q;
      for (int i = 4; i >= 1; i--) begin
         w_idx = last_q + 2'(i);
         if (REQ[w_idx]) begin
            w_win_found = 1'b1;
            w_win_id    = w_idx;
         end
      end
   end

   generate
      if (MAX_HOLD != 0) begin : g_tmo
         assign w_tmo_hit = (cnt_q == c_HOLD_LAST);
      end else begin : g_no_tmo
         assign w_tmo_hit = 1'b0;
      end
   endgenerate

   always_comb begin
      w_owner_req = REQ[data_q];
      w_release   = DONE | ~w_owner_req | w_tmo_hit;
      cnt_d       = (cnt_q == c_CNT_SAT) ? cnt_q : cnt_q + c_CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= 2'b00;
         last_q  <= 2'b11;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tmo_q <= 1'b0;
               if (w_win_found) begin
                  data_q  <= w_win_id;
                  last_q  <= w_win_id;
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  en_q    <= 1'b0;
                  // Timeout is only flagged when nothing else ended the grant.
                  tmo_q   <= w_tmo_hit & ~DONE & w_owner_req;
                  state_q <= ST_RELEASE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RELEASE: begin
               en_q    <= 1'b0;
               tmo_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               en_q    <= 1'b0;
               tmo_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Data = data_q;
   assign EN   = en_q;
   assign BUSY = busy_q;
   assign TMO  = tmo_q;

endmodule

`default_nettype wire

// File: doc/rr_req_encoder4_2.md
Name: rr_req_encoder4_2

Overview:
- Requester-side front end of the bus arbiter: a 4-input round-robin request encoder.
- Collects four raw request lines, picks one winner, and drives a registered 2-bit grant ID (Data) plus enable (EN).
- Data/EN feed the existing 2-to-4 grant decoder directly.
- Holds the grant until the owner releases, signals DONE, or exceeds a hold limit. A mandatory dead cycle separates consecutive grants.

Parameters:
- MAX_HOLD, 16, maximum GRANT cycles before forced release. 0 disables the timeout.
- HOLD_W, 5, hold counter width. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- REQ  input  4  request lines; bit i = requester i
- DONE  input  1  current owner finished; sampled only in GRANT
- Data  output  2  encoded ID of current/last winner (registered)
- EN  output  1  grant valid; high only in GRANT (registered)
- BUSY  output  1  high whenever state != IDLE (registered)
- TMO  output  1  one-cycle pulse on forced release (registered)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; Data=2'b00; EN=0; BUSY=0; TMO=0.
  - Round-robin pointer LAST=2'b11, so requester 0 has first priority. Hold counter=0.
  - Applies immediately, including mid-grant. Release of reset is synchronous to clk.
- States:
  - IDLE: arbitrate.
  - GRANT: EN=1, Data=owner.
  - RELEASE: one dead cycle, EN=0.
- IDLE:
  - REQ==0: stay, all outputs hold.
  - Any REQ bit set: winner = first set bit in search order LAST+1, LAST+2, LAST+3, LAST (mod 4).
  - At that edge: Data<=winner, LAST<=winner, EN<=1, BUSY<=1, counter<=0, state->GRANT.
  - Latency: REQ sampled at edge k, EN high from edge k onward (one cycle after REQ setup).
- GRANT, evaluated each edge:
  - Release condition R = DONE | ~REQ[Data] | (MAX_HOLD!=0 & counter==MAX_HOLD-1).
  - R false: counter<=counter+1, stay.
  - R true: EN<=0, state->RELEASE, Data holds.
  - TMO<=1 only if the timeout term is the sole cause (DONE=0 and REQ[Data]=1). DONE or owner drop in the same cycle as timeout counts as a normal release, TMO stays 0.
  - Requests from non-owners never preempt the owner.
- RELEASE: EN=0, TMO<=0, BUSY<=0, state->IDLE. REQ is ignored this cycle.
- Resulting timing:
  - Minimum EN low time between grants is 2 cycles (RELEASE + IDLE arbitration edge).
  - With MAX_HOLD=N, EN is high for at most N cycles.
- Fairness: a requester granted at edge k has lowest priority at its next arbitration. With all four REQ continuously high, grant order is 0,1,2,3,0,...
- Data holds its last value while EN=0. Consumers qualify Data with EN.
- DONE is ignored outside GRANT. A DONE high on the very arbitration edge does not affect the new grant.
- The hold counter saturates at 2^HOLD_W-1 when MAX_HOLD=0 (no wrap).

Test Plan:
- Reset then REQ=4'b0000 for 10 cycles -> EN=0, BUSY=0, Data=00, TMO=0 throughout. Assert rst_n=0 mid-GRANT -> EN=0 and BUSY=0 without waiting for a clk edge.
- REQ=4'b1111 held, DONE pulsed 1 cycle after 3 GRANT cycles, repeat -> Data sequence 0,1,2,3,0. EN high 4 cycles per grant, low exactly 2 cycles between grants.
- REQ=4'b0100 only, then drop REQ[2] after 5 GRANT cycles -> Data=2, EN high 5 cycles, then RELEASE, IDLE, EN stays 0, TMO=0.
- MAX_HOLD=16, REQ=4'b0001 held, DONE=0 -> EN high exactly 16 cycles, TMO pulses 1 cycle with EN fall. Regrant to 0 occurs 2 cycles later.
- Timeout cycle coincident with DONE=1 -> release at the same edge, TMO=0.
- Owner 1 in GRANT, REQ goes 4'b1011 -> no preemption. After release the next winner is 3 (order 2,3,0,1; bit 2 clear).
